serial_fifo_ctrl: RTL and testbench

//  Buffered COM port controller between devctrl (COM window) and async_receiver/async_transmitter.

---
 rtl/serial_fifo_ctrl.sv | 159 +++++++++++++++
 tb/tb_serial_fifo_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_fifo_ctrl.sv
// Buffered COM port: RX/TX byte FIFOs between the devctrl COM window and the
// async receiver/transmitter, plus a small TX launch FSM and the COM interrupt.
module serial_fifo_ctrl #(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic        mode_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        int_o,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o
);

  // state    | meaning
  // TX_IDLE  | no byte on the line from us; launch TX head if queued
  // TX_WAITB | start pulsed, waiting for transmitter busy to rise
  // TX_WAITD | transmitter busy, waiting for it to drop
  typedef enum logic [1:0] {TX_IDLE, TX_WAITB, TX_WAITD} tx_state_t;

  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_AW    = RX_DEPTH_LOG2;
  localparam int TX_AW    = TX_DEPTH_LOG2;
  localparam int RX_CW    = RX_DEPTH_LOG2 + 1;
  localparam int TX_CW    = TX_DEPTH_LOG2 + 1;

  logic [7:0]       rx_mem_q [RX_DEPTH];
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [RX_AW-1:0] rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [TX_AW-1:0] tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [RX_CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [TX_CW-1:0] tx_cnt_q, tx_cnt_d;
  logic             rx_ovr_q, rx_ovr_d;
  logic             tx_ovf_q, tx_ovf_d;
  tx_state_t        tx_state_q, tx_state_d;
  logic             txd_start_q, txd_start_d;
  logic [7:0]       txd_data_q, txd_data_d;

  logic rd_data, rd_stat, wr_data;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_pop, rx_push, tx_pop, tx_push;
  logic unused_save_bits;

  assign unused_save_bits = ^dataSave_i[31:8];

  assign rd_data = enable_i & readEnable_i & ~mode_i;
  assign rd_stat = enable_i & readEnable_i & mode_i;
  assign wr_data = enable_i & ~readEnable_i & ~mode_i;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));

  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign rx_pop  = rd_data & ~rx_empty;
  assign rx_push = rxdReady_i & (~rx_full | rx_pop);
  assign tx_pop  = (tx_state_q == TX_IDLE) & ~tx_empty;
  assign tx_push = wr_data & (~tx_full | tx_pop);

  always_comb begin
    rx_wptr_d = rx_push ? rx_wptr_q + RX_AW'(1) : rx_wptr_q;
    rx_rptr_d = rx_pop  ? rx_rptr_q + RX_AW'(1) : rx_rptr_q;
    tx_wptr_d = tx_push ? tx_wptr_q + TX_AW'(1) : tx_wptr_q;
    tx_rptr_d = tx_pop  ? tx_rptr_q + TX_AW'(1) : tx_rptr_q;

    rx_cnt_d = rx_cnt_q;
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + RX_CW'(1);
    else if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RX_CW'(1);

    tx_cnt_d = tx_cnt_q;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + TX_CW'(1);
    else if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TX_CW'(1);

    // Set is applied after the status-read clear so it wins on collision.
    rx_ovr_d = rd_stat ? 1'b0 : rx_ovr_q;
    tx_ovf_d = rd_stat ? 1'b0 : tx_ovf_q;
    if (rxdReady_i && !rx_push) rx_ovr_d = 1'b1;
    if (wr_data && !tx_push)    tx_ovf_d = 1'b1;
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    txd_start_d = 1'b0;
    txd_data_d  = txd_data_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_pop) begin
          txd_data_d  = tx_mem_q[tx_rptr_q];
          txd_start_d = 1'b1;
          tx_state_d  = TX_WAITB;
        end
      end
      TX_WAITB: if (txdBusy_i)  tx_state_d = TX_WAITD;
      TX_WAITD: if (!txdBusy_i) tx_state_d = TX_IDLE;
      default:  tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    dataLoad_o = '0;
    if (rd_data && !rx_empty) begin
      dataLoad_o = {24'b0, rx_mem_q[rx_rptr_q]};
    end else if (rd_stat) begin
      dataLoad_o[0]     = ~tx_full;
      dataLoad_o[1]     = ~rx_empty;
      dataLoad_o[2]     = rx_ovr_q;
      dataLoad_o[3]     = tx_ovf_q;
      dataLoad_o[15:8]  = 8'(rx_cnt_q);
      dataLoad_o[23:16] = 8'(tx_cnt_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= rxdData_i;
    if (tx_push) tx_mem_q[tx_wptr_q] <= dataSave_i[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wptr_q   <= '0;
      rx_rptr_q   <= '0;
      rx_cnt_q    <= '0;
      tx_wptr_q   <= '0;
      tx_rptr_q   <= '0;
      tx_cnt_q    <= '0;
      rx_ovr_q    <= 1'b0;
      tx_ovf_q    <= 1'b0;
      tx_state_q  <= TX_IDLE;
      txd_start_q <= 1'b0;
      txd_data_q  <= '0;
    end else begin
      rx_wptr_q   <= rx_wptr_d;
      rx_rptr_q   <= rx_rptr_d;
      rx_cnt_q    <= rx_cnt_d;
      tx_wptr_q   <= tx_wptr_d;
      tx_rptr_q   <= tx_rptr_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_ovr_q    <= rx_ovr_d;
      tx_ovf_q    <= tx_ovf_d;
      tx_state_q  <= tx_state_d;
      txd_start_q <= txd_start_d;
      txd_data_q  <= txd_data_d;
    end
  end

  assign int_o      = ~rx_empty;
  assign txdStart_o = txd_start_q;
  assign txdData_o  = txd_data_q;

endmodule

// File: tb/tb_serial_fifo_ctrl.sv
// Bench for serial_fifo_ctrl: vector table for basic register access, queue
// scoreboards for RX reads and TX launches, and a transmitter busy model.
module tb_serial_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_i = 1'b0;
  logic        readEnable_i = 1'b0;
  logic        mode_i = 1'b0;
  logic [31:0] dataSave_i = '0;
  logic [31:0] dataLoad_o;
  logic        int_o;
  logic        rxdReady_i = 1'b0;
  logic [7:0]  rxdData_i = '0;
  logic        txdBusy_i = 1'b0;
  logic        txdStart_o;
  logic [7:0]  txdData_o;

  serial_fifo_ctrl dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .readEnable_i(readEnable_i),
    .mode_i(mode_i), .dataSave_i(dataSave_i), .dataLoad_o(dataLoad_o),
    .int_o(int_o), .rxdReady_i(rxdReady_i), .rxdData_i(rxdData_i),
    .txdBusy_i(txdBusy_i), .txdStart_o(txdStart_o), .txdData_o(txdData_o)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] K_IDLE = 3'd0, K_RX = 3'd1, K_DRD = 3'd2,
                         K_SRD = 3'd3, K_DWR = 3'd4, K_SWR = 3'd5;

  typedef struct {
    logic [2:0]  kind;
    logic [7:0]  d;
    logic [31:0] exp_load;
    logic        exp_int;
  } vec_t;

  vec_t       vecs [10];
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         n_starts = 0;
  int         start_cyc [$];
  logic [7:0] rx_q [$];
  logic [7:0] tx_q [$];
  logic       model_en = 1'b0;
  logic       start_dly = 1'b0;
  int         busy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One access cycle starting at a negedge; returns at the following negedge.
  task automatic cycle(input logic en, input logic rd, input logic md, input logic [7:0] wd,
                       input logic rxv, input logic [7:0] rxd, output logic [31:0] load);
    enable_i = en; readEnable_i = rd; mode_i = md; dataSave_i = {24'hABCDEF, wd};
    rxdReady_i = rxv; rxdData_i = rxd;
    #1 load = dataLoad_o;
    @(negedge clk);
    enable_i = 1'b0; readEnable_i = 1'b0; mode_i = 1'b0; dataSave_i = '0;
    rxdReady_i = 1'b0; rxdData_i = '0;
  endtask

  task automatic stat(input string name, input logic [31:0] exp);
    logic [31:0] ld;
    cycle(1, 1, 1, 8'h00, 0, 8'h00, ld);
    check(name, ld, exp);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    logic [31:0] ld;
    cycle(0, 0, 0, 8'h00, 1, b, ld);
  endtask

  task automatic rd_sb(input string name);
    logic [31:0] ld;
    logic [31:0] exp;
    exp = (rx_q.size() != 0) ? {24'b0, rx_q.pop_front()} : 32'h0;
    cycle(1, 1, 0, 8'h00, 0, 8'h00, ld);
    check(name, ld, exp);
  endtask

  task automatic wr_sb(input logic [7:0] b, input logic accept);
    logic [31:0] ld;
    if (accept) tx_q.push_back(b);
    cycle(1, 0, 0, b, 0, 8'h00, ld);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // TX monitor followed by the busy model, both on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (txdStart_o) begin
        n_starts++;
        start_cyc.push_back(cyc);
        if (tx_q.size() != 0) check("tx_byte", {24'b0, txdData_o}, {24'b0, tx_q.pop_front()});
        else check("tx_unexpected_start", 32'd1, 32'd0);
      end
      if (model_en) begin
        if (start_dly) begin
          txdBusy_i = 1'b1; busy_cnt = 100; start_dly = 1'b0;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
          if (busy_cnt == 0) txdBusy_i = 1'b0;
        end
        if (txdStart_o) start_dly = 1'b1;
      end
    end
  end

  initial begin
    logic [31:0] ld;

    vecs[0] = '{K_SRD,  8'h00, 32'h0000_0001, 1'b0};
    vecs[1] = '{K_DRD,  8'h00, 32'h0000_0000, 1'b0};
    vecs[2] = '{K_RX,   8'h41, 32'h0000_0000, 1'b1};
    vecs[3] = '{K_RX,   8'h42, 32'h0000_0000, 1'b1};
    vecs[4] = '{K_SRD,  8'h00, 32'h0000_0203, 1'b1};
    vecs[5] = '{K_DRD,  8'h00, 32'h0000_0041, 1'b1};
    vecs[6] = '{K_DRD,  8'h00, 32'h0000_0042, 1'b0};
    vecs[7] = '{K_DRD,  8'h00, 32'h0000_0000, 1'b0};
    vecs[8] = '{K_SWR,  8'hFF, 32'h0000_0000, 1'b0};
    vecs[9] = '{K_SRD,  8'h00, 32'h0000_0001, 1'b0};

    idle(3);
    rst = 1'b0;
    idle(1);
    check("rst_int", {31'b0, int_o}, 32'd0);
    check("rst_start", {31'b0, txdStart_o}, 32'd0);
    check("rst_txdata", {24'b0, txdData_o}, 32'd0);
    check("rst_load_idle", dataLoad_o, 32'd0);

    for (int i = 0; i < 10; i++) begin
      unique case (vecs[i].kind)
        K_RX:    cycle(0, 0, 0, 8'h00, 1, vecs[i].d, ld);
        K_DRD:   cycle(1, 1, 0, 8'h00, 0, 8'h00, ld);
        K_SRD:   cycle(1, 1, 1, 8'h00, 0, 8'h00, ld);
        K_DWR:   cycle(1, 0, 0, vecs[i].d, 0, 8'h00, ld);
        K_SWR:   cycle(1, 0, 1, vecs[i].d, 0, 8'h00, ld);
        default: cycle(0, 0, 0, 8'h00, 0, 8'h00, ld);
      endcase
      check($sformatf("vec%0d_load", i), ld, vecs[i].exp_load);
      check($sformatf("vec%0d_int", i), {31'b0, int_o}, {31'b0, vecs[i].exp_int});
    end

    // RX overrun: 17th byte lands on a status read; set beats clear.
    for (int i = 0; i < 16; i++) begin
      rx_q.push_back(8'h80 + 8'(i));
      rx_byte(8'h80 + 8'(i));
    end
    cycle(1, 1, 1, 8'h00, 1, 8'hEE, ld);
    check("ovr_collide_load", ld, 32'h0000_1003);
    stat("ovr_set", 32'h0000_1007);
    stat("ovr_cleared", 32'h0000_1003);
    check("int_full", {31'b0, int_o}, 32'd1);

    // RX full, push coincident with pop.
    cycle(1, 1, 0, 8'h00, 1, 8'h99, ld);
    check("full_pushpop_load", ld, {24'b0, rx_q.pop_front()});
    rx_q.push_back(8'h99);
    stat("full_pushpop_stat", 32'h0000_1003);
    for (int i = 0; i < 16; i++) rd_sb($sformatf("drain%0d", i));
    stat("rx_drained", 32'h0000_0001);

    // Empty + push + read.
    cycle(1, 1, 0, 8'h00, 1, 8'h77, ld);
    check("empty_pushread_load", ld, 32'h0);
    rx_q.push_back(8'h77);
    stat("empty_pushread_stat", 32'h0000_0103);
    rd_sb("empty_pushread_data");
    check("int_clear", {31'b0, int_o}, 32'd0);

    // Two TX bytes with the busy model.
    model_en = 1'b1;
    wr_sb(8'h55, 1'b1);
    wr_sb(8'hAA, 1'b1);
    for (int i = 0; i < 400 && n_starts < 2; i++) @(negedge clk);
    check("tx2_starts", n_starts, 32'd2);
    if (start_cyc.size() >= 2) check("tx2_gap", start_cyc[1] - start_cyc[0], 32'd103);
    idle(120);
    model_en = 1'b0;

    // TX overflow with a byte held in flight by a stuck busy.
    txdBusy_i = 1'b1;
    wr_sb(8'h10, 1'b1);
    idle(3);
    for (int i = 0; i < 17; i++) wr_sb(8'h20 + 8'(i), i < 16);
    stat("tx_ovf_set", 32'h0010_0008);
    stat("tx_ovf_cleared", 32'h0010_0000);
    txdBusy_i = 1'b0;
    idle(1);
    wr_sb(8'h5A, 1'b1);
    stat("tx_full_pushpop", 32'h0010_0000);
    txdBusy_i = 1'b1;
    idle(2);
    txdBusy_i = 1'b0;
    model_en = 1'b1;
    for (int i = 0; i < 2500 && tx_q.size() != 0; i++) @(negedge clk);
    check("tx_drained", tx_q.size(), 32'd0);
    idle(120);
    check("tx_total_starts", n_starts, 32'd20);
    stat("final_stat", 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
